msg_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one UART message sender between N requesters in the J1 SoC. Each requester posts an 8-bit message command. The block buffers one pending command per requester and dispatches them one at a time over the sender's `str`/`command`/`busy` handshake. It reports completion or timeout back to each requester.

---
 rtl/msg_tx_scheduler_pkg.sv | 21 ++
 rtl/msg_tx_scheduler_rr_arbiter.sv | 34 +++
 rtl/msg_tx_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_msg_tx_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/msg_tx_scheduler_pkg.sv
// msg_sched_pkg: shared types and defaults for the message TX scheduler.
//   state_e       - scheduler FSM states (REARM/GAP only reachable with MSG_SCHED_REARM_EN)
//   CMD_W         - message command width
//   N_DEF, TIMEOUT_DEF, REARM_GAP_DEF - default parameter values
package msg_sched_pkg;

    localparam int unsigned CMD_W         = 8;
    localparam int unsigned N_DEF         = 4;
    localparam int unsigned TIMEOUT_DEF   = 16;
    localparam int unsigned REARM_GAP_DEF = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        REARM     = 3'd4,
        GAP       = 3'd5
    } state_e;

endpackage

// File: rtl/msg_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant over a pending vector.
//   pend_i  - pending flags, one per requester
//   ptr_i   - last serviced index; search starts at ptr_i+1 (mod N)
//   grant_c - first pending index found
//   valid_c - at least one requester pending
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         pend_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] grant_c,
    output logic                 valid_c
);

    localparam int unsigned IDX_W = $clog2(N);

    // Walk the N candidates in priority order; the first hit wins.
    always_comb begin
        int unsigned idx;
        grant_c = '0;
        valid_c = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = 32'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!valid_c && pend_i[IDX_W'(idx)]) begin
                valid_c = 1'b1;
                grant_c = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/msg_tx_scheduler.sv
// msg_tx_scheduler: shares one UART message sender between N requesters.
// Each requester has a one-deep command buffer; buffered commands are
// dispatched round-robin over the sender's str/command/busy handshake.
// Optional feature macro: MSG_SCHED_REARM_EN (re-arm strobe + idle gap after
// every completed message).
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   req_i, cmd_i  - per-requester request and 8-bit command (cmd_i[8i+7:8i])
//   ack_o         - request accepted into pending (pulse)
//   done_o        - requester's message completed (pulse)
//   drop_o        - request refused or dispatch timed out (pulse)
//   pending_o     - pending flags
//   cmd_o, str_o  - command and start strobe to the sender
//   busy_i        - sender busy
//   timeout_o     - sticky: some dispatch timed out since reset
module msg_tx_scheduler
    import msg_sched_pkg::*;
#(
    parameter int unsigned N         = N_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned REARM_GAP = REARM_GAP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_i,
    input  logic [CMD_W*N-1:0] cmd_i,
    output logic [N-1:0]       ack_o,
    output logic [N-1:0]       done_o,
    output logic [N-1:0]       drop_o,
    output logic [N-1:0]       pending_o,
    output logic [CMD_W-1:0]   cmd_o,
    output logic               str_o,
    input  logic               busy_i,
    output logic               timeout_o
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    if (N < 2 || N > 8 || TIMEOUT < 1 || REARM_GAP < 1) begin : g_param_check
        $error("msg_tx_scheduler: parameter out of range");
    end

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           ptr_q, ptr_d;
    logic [IDX_W-1:0]           g_q, g_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic [N-1:0]               pending_q, pending_d;
    logic [N-1:0][CMD_W-1:0]    cmd_mem_q, cmd_mem_d;
    logic [CMD_W-1:0]           cmd_q, cmd_d;
    logic                       str_q, str_d;
    logic [N-1:0]               ack_q, ack_d;
    logic [N-1:0]               done_q, done_d;
    logic [N-1:0]               drop_q, drop_d;
    logic                       timeout_q, timeout_d;
    logic [N-1:0]               clr_c;
    logic [IDX_W-1:0]           grant_c;
    logic                       valid_c;

`ifdef MSG_SCHED_REARM_EN
    localparam int unsigned GAP_W = $clog2(REARM_GAP + 1);
    logic [GAP_W-1:0]           gap_q, gap_d;
`endif

    rr_arbiter #(.N(N)) u_arb (
        .pend_i  (pending_q),
        .ptr_i   (ptr_q),
        .grant_c (grant_c),
        .valid_c (valid_c)
    );

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= IDX_W'(N - 1);
            g_q       <= '0;
            timer_q   <= '0;
            pending_q <= '0;
            cmd_mem_q <= '0;
            cmd_q     <= '0;
            str_q     <= 1'b0;
            ack_q     <= '0;
            done_q    <= '0;
            drop_q    <= '0;
            timeout_q <= 1'b0;
`ifdef MSG_SCHED_REARM_EN
            gap_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            g_q       <= g_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            cmd_mem_q <= cmd_mem_d;
            cmd_q     <= cmd_d;
            str_q     <= str_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
            timeout_q <= timeout_d;
`ifdef MSG_SCHED_REARM_EN
            gap_q     <= gap_d;
`endif
        end
    end

    // Next-state, dispatch and acceptance logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        g_d       = g_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        cmd_mem_d = cmd_mem_q;
        cmd_d     = cmd_q;
        str_d     = 1'b0;
        ack_d     = '0;
        done_d    = '0;
        drop_d    = '0;
        timeout_d = timeout_q;
        clr_c     = '0;
`ifdef MSG_SCHED_REARM_EN
        gap_d     = gap_q;
`endif

        case (state_q)
            IDLE: begin
                if (valid_c) begin
                    g_d     = grant_c;
                    cmd_d   = cmd_mem_q[grant_c];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                str_d   = 1'b1;
                timer_d = TMR_W'(TIMEOUT);
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_i) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == '0) begin
                    drop_d[g_q] = 1'b1;
                    timeout_d   = 1'b1;
                    clr_c[g_q]  = 1'b1;
                    ptr_d       = g_q;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!busy_i) begin
                    done_d[g_q] = 1'b1;
                    clr_c[g_q]  = 1'b1;
                    ptr_d       = g_q;
`ifdef MSG_SCHED_REARM_EN
                    state_d     = REARM;
`else
                    state_d     = IDLE;
`endif
                end
            end
`ifdef MSG_SCHED_REARM_EN
            // Extra strobe kicks a sender parked in its stop state back to idle.
            REARM: begin
                str_d   = 1'b1;
                gap_d   = GAP_W'(REARM_GAP - 1);
                state_d = GAP;
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // A slot being freed this cycle can take a new request immediately.
        for (int unsigned i = 0; i < N; i++) begin
            if (req_i[i]) begin
                if (!pending_q[i] || clr_c[i]) begin
                    pending_d[i] = 1'b1;
                    cmd_mem_d[i] = cmd_i[i*CMD_W +: CMD_W];
                    ack_d[i]     = 1'b1;
                end else begin
                    drop_d[i] = 1'b1;
                end
            end else if (clr_c[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    assign ack_o     = ack_q;
    assign done_o    = done_q;
    assign drop_o    = drop_q;
    assign pending_o = pending_q;
    assign cmd_o     = cmd_q;
    assign str_o     = str_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_msg_tx_scheduler.sv
// tb_msg_tx_scheduler: randomized bench for msg_tx_scheduler against a
// transaction-timeline reference model (pending buffers, round-robin pick,
// event times relative to each grant). Honors MSG_SCHED_REARM_EN.
module tb_msg_tx_scheduler;
    import msg_sched_pkg::*;

    localparam int NR = 4;
    localparam int TO = 16;
    localparam int RG = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   req_i = '0;
    logic [8*NR-1:0] cmd_i = '0;
    logic            busy_i = 1'b0;
    logic [NR-1:0]   ack_o, done_o, drop_o, pending_o;
    logic [7:0]      cmd_o;
    logic            str_o, timeout_o;

    msg_tx_scheduler #(.N(NR), .TIMEOUT(TO), .REARM_GAP(RG)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .cmd_i     (cmd_i),
        .ack_o     (ack_o),
        .done_o    (done_o),
        .drop_o    (drop_o),
        .pending_o (pending_o),
        .cmd_o     (cmd_o),
        .str_o     (str_o),
        .busy_i    (busy_i),
        .timeout_o (timeout_o)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: buffers, last-served pointer and the in-flight message
    // described by its grant cycle; outputs are derived from elapsed time.
    bit [NR-1:0] m_pend;
    logic [7:0]  m_cmd [NR];
    int          m_ptr, m_g, m_t0, m_idle_from, m_rearm_at, m_cyc;
    bit          m_active, m_busy_seen, m_timeout;
    logic [NR-1:0] e_ack, e_done, e_drop;
    logic [7:0]  e_cmd;
    bit          e_str;

    // Sender emulation state and stimulus knobs.
    int snd_wait = -1;
    int snd_len  = 0;
    bit resp_en  = 1'b1;

    task automatic model_reset();
        m_pend = '0;
        for (int i = 0; i < NR; i++) m_cmd[i] = 8'h00;
        m_ptr = NR - 1; m_g = 0; m_t0 = 0; m_idle_from = 0; m_rearm_at = -1; m_cyc = 0;
        m_active = 0; m_busy_seen = 0; m_timeout = 0;
        e_ack = '0; e_done = '0; e_drop = '0; e_cmd = 8'h00; e_str = 0;
    endtask

    function automatic int rr_pick(input bit [NR-1:0] p, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (p[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_step();
        bit [NR-1:0] freed;
        int el;
        freed = '0;
        e_str = 0; e_ack = '0; e_done = '0; e_drop = '0;
        if (m_rearm_at == m_cyc) e_str = 1;
        if (m_active) begin
            el = m_cyc - m_t0;
            if (el == 1) begin
                e_str = 1;
            end else if (el >= 2) begin
                if (!m_busy_seen) begin
                    if (busy_i) begin
                        m_busy_seen = 1;
                    end else if (el == 2 + TO) begin
                        e_drop[m_g] = 1'b1; m_timeout = 1; freed[m_g] = 1'b1;
                        m_ptr = m_g; m_active = 0; m_idle_from = m_cyc + 1;
                    end
                end else if (!busy_i) begin
                    e_done[m_g] = 1'b1; freed[m_g] = 1'b1;
                    m_ptr = m_g; m_active = 0;
`ifdef MSG_SCHED_REARM_EN
                    m_rearm_at  = m_cyc + 1;
                    m_idle_from = m_cyc + 2 + RG;
`else
                    m_idle_from = m_cyc + 1;
`endif
                end
            end
        end else if (m_cyc >= m_idle_from && m_pend != '0) begin
            m_g = rr_pick(m_pend, m_ptr);
            e_cmd = m_cmd[m_g];
            m_active = 1; m_busy_seen = 0; m_t0 = m_cyc;
        end
        for (int i = 0; i < NR; i++) begin
            if (req_i[i]) begin
                if (!m_pend[i] || freed[i]) begin
                    m_pend[i] = 1'b1; m_cmd[i] = cmd_i[i*8 +: 8]; e_ack[i] = 1'b1;
                end else begin
                    e_drop[i] = 1'b1;
                end
            end else if (freed[i]) begin
                m_pend[i] = 1'b0;
            end
        end
        m_cyc++;
    endtask

    task automatic compare_all();
        check_eq("ack_o",     32'(ack_o),     32'(e_ack));
        check_eq("done_o",    32'(done_o),    32'(e_done));
        check_eq("drop_o",    32'(drop_o),    32'(e_drop));
        check_eq("pending_o", 32'(pending_o), 32'(m_pend));
        check_eq("cmd_o",     32'(cmd_o),     32'(e_cmd));
        check_eq("str_o",     32'(str_o),     32'(e_str));
        check_eq("timeout_o", 32'(timeout_o), 32'(m_timeout));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ack"},     32'(ack_o),     32'h0);
        check_eq({tag, "_done"},    32'(done_o),    32'h0);
        check_eq({tag, "_drop"},    32'(drop_o),    32'h0);
        check_eq({tag, "_pending"}, 32'(pending_o), 32'h0);
        check_eq({tag, "_cmd"},     32'(cmd_o),     32'h0);
        check_eq({tag, "_str"},     32'(str_o),     32'h0);
        check_eq({tag, "_timeout"}, 32'(timeout_o), 32'h0);
    endtask

    // Drive requests and the emulated sender; called at the falling edge.
    task automatic drive_inputs(input int req_pct);
        for (int i = 0; i < NR; i++) begin
            req_i[i] = ($urandom_range(0, 99) < req_pct);
            cmd_i[i*8 +: 8] = 8'($urandom);
        end
        if (str_o && snd_wait < 0 && snd_len == 0 && resp_en) snd_wait = $urandom_range(0, 3);
        if (snd_wait == 0) begin
            snd_len  = $urandom_range(1, 10);
            snd_wait = -1;
        end else if (snd_wait > 0) begin
            snd_wait--;
        end
        busy_i = (snd_len > 0);
        if (snd_len > 0) snd_len--;
    endtask

    task automatic run_cycles(input int n, input int req_pct);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
            drive_inputs(req_pct);
        end
    endtask

    initial begin
        bit reached;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        @(negedge clk);
        rst = 1'b1;
        drive_inputs(0);

        // Heavy contention, then moderate load.
        run_cycles(300, 60);
        run_cycles(300, 15);

        // Sender never answers: every dispatch must time out.
        resp_en = 1'b0;
        run_cycles(250, 20);
        check_eq("timeout_sticky", 32'(timeout_o), 32'h1);
        resp_en = 1'b1;
        run_cycles(300, 30);

        // Reset while a message is in its busy phase.
        reached = 0;
        for (int c = 0; c < 400 && !reached; c++) begin
            run_cycles(1, 30);
            if (m_active && m_busy_seen && busy_i) reached = 1;
        end
        check_eq("reach_wait_done", 32'(reached), 32'h1);
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        check_all_zero("midreset_hold");
        model_reset();
        req_i = '0; busy_i = 1'b0; snd_wait = -1; snd_len = 0;
        rst = 1'b1;
        run_cycles(40, 0);
        run_cycles(300, 40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
